// File: rtl/instr_dual_issue_queue_if.sv
// instr_dual_issue_queue_if: fetch/dispatch-side bundle of the dual-issue instruction queue
interface instr_dual_issue_queue_if #(parameter int DEPTH = 8);
  logic                     flush;
  logic                     enq0_valid;
  logic [31:0]              enq0_instr;
  logic                     enq1_valid;
  logic [31:0]              enq1_instr;
  logic                     enq_ready;
  logic [1:0]               deq_count;
  logic [31:0]              instr_out_0;
  logic [31:0]              instr_out_1;
  logic                     out_valid_0;
  logic                     out_valid_1;
  logic [$clog2(DEPTH):0]   count;
  logic                     instr_queue_empty;
  logic                     deq_err;
  modport slave (
    input  flush, enq0_valid, enq0_instr, enq1_valid, enq1_instr, deq_count,
    output enq_ready, instr_out_0, instr_out_1, out_valid_0, out_valid_1, count,
           instr_queue_empty, deq_err
  );
  modport master (
    output flush, enq0_valid, enq0_instr, enq1_valid, enq1_instr, deq_count,
    input  enq_ready, instr_out_0, instr_out_1, out_valid_0, out_valid_1, count,
           instr_queue_empty, deq_err
  );
endinterface

// File: rtl/instr_dual_issue_queue.sv
// instr_dual_issue_queue: circular buffer feeding the two oldest instructions to dual dispatch
module instr_dual_issue_queue #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic                  clk,
  input logic                  rst,
  instr_dual_issue_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_deq_err;
  logic          w_enq_ready, w_wr0, w_wr1, w_err;
  logic [1:0]    w_enq_n, w_deq_req, w_deq_eff;
  logic [31:0]   w_wdata0;
  always_comb begin
    w_enq_ready = r_count <= CW'(DEPTH - 2);
    w_wr0       = w_enq_ready && !q.flush && (q.enq0_valid || q.enq1_valid);
    w_wr1       = w_enq_ready && !q.flush && q.enq0_valid && q.enq1_valid;
    w_enq_n     = w_wr1 ? 2'd2 : w_wr0 ? 2'd1 : 2'd0;
    w_wdata0    = q.enq0_valid ? q.enq0_instr : q.enq1_instr;
    w_deq_req   = (q.deq_count == 2'd3) ? 2'd2 : q.deq_count;
    // an over-count request only happens with count < 2, so its low bits are the clamp
    w_deq_eff   = (CW'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;
    w_err       = (q.deq_count == 2'd3) || (CW'(q.deq_count) > r_count);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_deq_err <= 1'b0;
    end else if (q.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_eff);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_eff);
      if (w_err) r_deq_err <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (w_wr0) r_mem[r_tail] <= w_wdata0;
    if (w_wr1) r_mem[r_tail + AW'(1)] <= q.enq1_instr;
  end
  assign q.out_valid_0       = r_count >= CW'(1);
  assign q.out_valid_1       = r_count >= CW'(2);
  assign q.instr_out_0       = q.out_valid_0 ? r_mem[r_head] : NOP_INSTR;
  assign q.instr_out_1       = q.out_valid_1 ? r_mem[r_head + AW'(1)] : NOP_INSTR;
  assign q.enq_ready         = w_enq_ready;
  assign q.count             = r_count;
  assign q.instr_queue_empty = r_count == '0;
  assign q.deq_err           = r_deq_err;
endmodule

// File: tb/tb_instr_dual_issue_queue.sv
// tb_instr_dual_issue_queue: directed table-driven check of the dual-issue queue (DEPTH=8)
module tb_instr_dual_issue_queue;
  localparam logic [31:0] N = 32'h00000013;
  localparam logic [31:0] A = 32'h002081B3;
  localparam logic [31:0] M = 32'h022082B3;
  typedef struct {
    logic        fl;
    logic        v0;
    logic [31:0] i0;
    logic        v1;
    logic [31:0] i1;
    logic [1:0]  deq;
    int          e_cnt;
    logic [31:0] e_o0;
    logic [31:0] e_o1;
    logic        e_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tv[$];
  instr_dual_issue_queue_if #(.DEPTH(8)) qi();
  instr_dual_issue_queue #(.DEPTH(8), .NOP_INSTR(N)) dut (.clk(clk), .rst(rst), .q(qi.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] w(int k);
    return 32'hC0DE0000 + k;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check_all(string tag, int e_cnt, logic [31:0] e_o0, logic [31:0] e_o1, logic e_err);
    chk({tag, " count"}, 32'(qi.count), 32'(e_cnt));
    chk({tag, " instr_out_0"}, qi.instr_out_0, e_o0);
    chk({tag, " instr_out_1"}, qi.instr_out_1, e_o1);
    chk({tag, " out_valid_0"}, 32'(qi.out_valid_0), 32'(e_cnt >= 1));
    chk({tag, " out_valid_1"}, 32'(qi.out_valid_1), 32'(e_cnt >= 2));
    chk({tag, " enq_ready"}, 32'(qi.enq_ready), 32'(e_cnt <= 6));
    chk({tag, " empty"}, 32'(qi.instr_queue_empty), 32'(e_cnt == 0));
    chk({tag, " deq_err"}, 32'(qi.deq_err), 32'(e_err));
  endtask
  task automatic drive(logic fl, logic v0, logic [31:0] i0, logic v1, logic [31:0] i1, logic [1:0] deq);
    qi.flush = fl;
    qi.enq0_valid = v0;
    qi.enq0_instr = i0;
    qi.enq1_valid = v1;
    qi.enq1_instr = i1;
    qi.deq_count = deq;
    @(posedge clk);
    #1;
    qi.flush = 1'b0;
    qi.enq0_valid = 1'b0;
    qi.enq1_valid = 1'b0;
    qi.deq_count = 2'd0;
  endtask
  initial begin
    tv.push_back('{0, 1, A,     1, M,     2'd0, 2, A,     M,     0});
    tv.push_back('{0, 0, 0,     0, 0,     2'd2, 0, N,     N,     0});
    tv.push_back('{0, 0, 0,     1, w(1),  2'd0, 1, w(1),  N,     0});
    tv.push_back('{0, 1, w(2),  1, w(3),  2'd0, 3, w(1),  w(2),  0});
    tv.push_back('{0, 1, w(4),  1, w(5),  2'd2, 3, w(3),  w(4),  0});
    tv.push_back('{0, 1, w(6),  1, w(7),  2'd0, 5, w(3),  w(4),  0});
    tv.push_back('{0, 1, w(8),  1, w(9),  2'd0, 7, w(3),  w(4),  0});
    tv.push_back('{0, 1, w(30), 1, w(31), 2'd0, 7, w(3),  w(4),  0});
    tv.push_back('{0, 0, 0,     0, 0,     2'd2, 5, w(5),  w(6),  0});
    tv.push_back('{0, 0, 0,     0, 0,     2'd2, 3, w(7),  w(8),  0});
    tv.push_back('{0, 1, w(10), 1, w(11), 2'd0, 5, w(7),  w(8),  0});
    tv.push_back('{0, 1, w(12), 1, w(13), 2'd0, 7, w(7),  w(8),  0});
    tv.push_back('{0, 0, 0,     0, 0,     2'd1, 6, w(8),  w(9),  0});
    tv.push_back('{0, 1, w(14), 1, w(15), 2'd0, 8, w(8),  w(9),  0});
    tv.push_back('{0, 0, 0,     0, 0,     2'd2, 6, w(10), w(11), 0});
    tv.push_back('{1, 1, w(16), 1, w(17), 2'd1, 0, N,     N,     0});
    tv.push_back('{0, 1, w(18), 0, 0,     2'd0, 1, w(18), N,     0});
    tv.push_back('{0, 0, 0,     0, 0,     2'd2, 0, N,     N,     1});
    tv.push_back('{0, 1, w(19), 1, w(20), 2'd0, 2, w(19), w(20), 1});
    tv.push_back('{0, 1, w(21), 1, w(22), 2'd0, 4, w(19), w(20), 1});
    tv.push_back('{0, 0, 0,     0, 0,     2'd3, 2, w(21), w(22), 1});
    tv.push_back('{0, 0, 0,     0, 0,     2'd0, 2, w(21), w(22), 1});
    qi.flush = 1'b0;
    qi.enq0_valid = 1'b0;
    qi.enq0_instr = '0;
    qi.enq1_valid = 1'b0;
    qi.enq1_instr = '0;
    qi.deq_count = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, N, N, 0);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].fl, tv[i].v0, tv[i].i0, tv[i].v1, tv[i].i1, tv[i].deq);
      check_all($sformatf("vec%0d", i), tv[i].e_cnt, tv[i].e_o0, tv[i].e_o1, tv[i].e_err);
    end
    drive(0, 0, 0, 1, w(23), 2'd0);
    check_all("pre_rst", 3, w(21), w(22), 1);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, N, N, 0);
    #1 rst = 1'b0;
    drive(0, 1, w(24), 1, w(25), 2'd0);
    drive(0, 1, w(26), 1, w(27), 2'd0);
    check_all("fill4", 4, w(24), w(25), 0);
    drive(0, 0, 0, 0, 0, 2'd3);
    check_all("deq3", 2, w(26), w(27), 1);
    drive(1, 0, 0, 0, 0, 2'd0);
    check_all("flush_err_kept", 0, N, N, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
